// File: rtl/bist_misr_compactor.sv
// bist_misr_compactor
//   Multiple-input signature register that compacts CUT responses for BIST.
//   A run starts on `start`. It folds PAT_COUNT valid responses into a Galois
//   MISR, then compares the final signature with `golden`.
//
//   Optional build macro: MISR_XMASK_EN
//     When defined, the x_mask input is added. Each set bit forces the matching
//     resp_in bit to 0 before compaction, so unknown (X) CUT outputs are blocked.
//
//   Ports
//     clk         system clock, rising-edge
//     rst         synchronous active-high reset
//     start       one-cycle run request (honoured in IDLE / DONE)
//     resp_valid  resp_in holds a valid CUT response
//     resp_in     CUT response word
//     x_mask      per-bit response blocking (MISR_XMASK_EN only)
//     golden      expected final signature, stable from start to done
//     busy        run in progress
//     done        run finished, signature / pass frozen
//     pass        final signature matched golden (meaningful while done)
//     signature   current MISR contents
//     pat_cnt     responses compacted in the current / last run
module bist_misr_compactor #(
    parameter int              WIDTH     = 36,
    parameter int              CNT_W     = 16,
    parameter int              PAT_COUNT = 1000,
    parameter logic [WIDTH-1:0] POLY     = 36'h000000801,
    parameter logic [WIDTH-1:0] SEED     = 36'h0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [WIDTH-1:0] resp_in,
`ifdef MISR_XMASK_EN
    input  logic [WIDTH-1:0] x_mask,
`endif
    input  logic [WIDTH-1:0] golden,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [WIDTH-1:0] signature,
    output logic [CNT_W-1:0] pat_cnt
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PAT_COUNT - 1);

    state_t           state;
    logic [WIDTH-1:0] resp_eff;
    logic [WIDTH-1:0] next_sig;
    logic             last_resp;

`ifdef MISR_XMASK_EN
    assign resp_eff = resp_in & ~x_mask;
`else
    assign resp_eff = resp_in;
`endif

    // One Galois stage per signature bit. The bit shifts up from its lower
    // neighbour. The MSB is fed back into the positions selected by POLY.
    // Then the response bit is added.
    for (genvar k = 0; k < WIDTH; k++) begin : g_stage
        if (k == 0) begin : g_lsb
            assign next_sig[k] = (POLY[k] & signature[WIDTH-1]) ^ resp_eff[k];
        end else begin : g_mid
            assign next_sig[k] = signature[k-1] ^ (POLY[k] & signature[WIDTH-1]) ^ resp_eff[k];
        end
    end

    // The response that brings the count to PAT_COUNT closes the run.
    assign last_resp = resp_valid && (pat_cnt == LAST_IDX);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            signature <= '0;
            pat_cnt   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state     <= RUN;
                        signature <= SEED;
                        pat_cnt   <= '0;
                        busy      <= 1'b1;
                        done      <= 1'b0;
                        pass      <= 1'b0;
                    end
                end
                RUN: begin
                    if (resp_valid) begin
                        signature <= next_sig;
                        pat_cnt   <= pat_cnt + 1'b1;
                        if (last_resp) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            // Compare the value being written, not the old one.
                            pass  <= (next_sig == golden);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    pass  <= 1'b0;
                end
            endcase
        end
    end

endmodule
